// File: rtl/menu_pkg.sv
// Shared types and text tables for the boxed menu renderer.
// Character codes: 0 = space, 1..26 = A..Z, 27..36 = 0..9.
package menu_pkg;

    typedef enum logic {
        ST_NAV  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam int unsigned GLYPH_W  = 8;
    localparam int unsigned GLYPH_H  = 8;
    localparam int unsigned TEXT_LEN = 6;

    localparam logic [5:0] CH_SPACE = 6'd0;
    localparam logic [5:0] CH_A     = 6'd1;
    localparam logic [5:0] CH_0     = 6'd27;

    localparam logic [8*TEXT_LEN-1:0] ITEM_TEXT_0 = "START ";
    localparam logic [8*TEXT_LEN-1:0] ITEM_TEXT_1 = "SCORES";
    localparam logic [8*TEXT_LEN-1:0] ITEM_TEXT_2 = "QUIT  ";
    localparam logic [8*TEXT_LEN-1:0] ITEM_BLANK  = {TEXT_LEN{8'h20}};

    function automatic logic [5:0] ascii_to_code(input logic [7:0] c);
        if (c >= "A" && c <= "Z") return CH_A + 6'(c - "A");
        if (c >= "0" && c <= "9") return CH_0 + 6'(c - "0");
        return CH_SPACE;
    endfunction

    // Rows beyond the text table, and columns past TEXT_LEN, render blank.
    function automatic logic [5:0] item_char(input logic [2:0] item, input logic [15:0] col);
        logic [8*TEXT_LEN-1:0] s;
        logic [5:0]            code;
        case (item)
            3'd0:    s = ITEM_TEXT_0;
            3'd1:    s = ITEM_TEXT_1;
            3'd2:    s = ITEM_TEXT_2;
            default: s = ITEM_BLANK;
        endcase
        code = CH_SPACE;
        for (int unsigned k = 0; k < TEXT_LEN; k++) begin
            if (col == 16'(k)) code = ascii_to_code(s[8*(TEXT_LEN-1-k) +: 8]);
        end
        return code;
    endfunction

endpackage

// File: rtl/menu_font_rom.sv
// Synchronous 8x8 glyph ROM (space, A-Z, 0-9); one-cycle read latency.
// Bit 7 of each row byte is the leftmost pixel.
module menu_font_rom
    import menu_pkg::*;
(
    input  logic       clk,
    input  logic [5:0] code_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    logic [63:0] glyph;
    logic [7:0]  bits_d;
    logic [7:0]  bits_q;

    always_comb begin
        case (code_i)
            6'd1:    glyph = 64'h183C66667E666600; // A
            6'd2:    glyph = 64'h7C66667C66667C00;
            6'd3:    glyph = 64'h3C66606060663C00;
            6'd4:    glyph = 64'h786C6666666C7800;
            6'd5:    glyph = 64'h7E60607860607E00;
            6'd6:    glyph = 64'h7E60607860606000;
            6'd7:    glyph = 64'h3C66606E66663C00;
            6'd8:    glyph = 64'h6666667E66666600;
            6'd9:    glyph = 64'h3C18181818183C00;
            6'd10:   glyph = 64'h1E0C0C0C0CCC7800;
            6'd11:   glyph = 64'h666C7870786C6600;
            6'd12:   glyph = 64'h6060606060607E00;
            6'd13:   glyph = 64'h63777F6B63636300;
            6'd14:   glyph = 64'h66767E7E6E666600;
            6'd15:   glyph = 64'h3C66666666663C00;
            6'd16:   glyph = 64'h7C66667C60606000;
            6'd17:   glyph = 64'h3C666666663C0E00;
            6'd18:   glyph = 64'h7C66667C786C6600;
            6'd19:   glyph = 64'h3C66603C06663C00;
            6'd20:   glyph = 64'h7E18181818181800;
            6'd21:   glyph = 64'h6666666666663C00;
            6'd22:   glyph = 64'h66666666663C1800;
            6'd23:   glyph = 64'h6363636B7F776300;
            6'd24:   glyph = 64'h66663C183C666600;
            6'd25:   glyph = 64'h6666663C18181800;
            6'd26:   glyph = 64'h7E060C1830607E00; // Z
            6'd27:   glyph = 64'h3C666E7666663C00; // 0
            6'd28:   glyph = 64'h1838181818187E00;
            6'd29:   glyph = 64'h3C66060C30607E00;
            6'd30:   glyph = 64'h3C66061C06663C00;
            6'd31:   glyph = 64'h0C1C3C6C7E0C0C00;
            6'd32:   glyph = 64'h7E607C0606663C00;
            6'd33:   glyph = 64'h3C66607C66663C00;
            6'd34:   glyph = 64'h7E660C1818181800;
            6'd35:   glyph = 64'h3C66663C66663C00;
            6'd36:   glyph = 64'h3C66663E06663C00; // 9
            default: glyph = 64'h0000000000000000;
        endcase
        bits_d = glyph[{3'd7 - row_i, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        bits_q <= bits_d;
    end

    assign bits_o = bits_q;

endmodule

// File: rtl/menu_renderer.sv
// Boxed multi-item text menu overlay with button-driven cursor, frame-synced
// highlight and blink, and a one-cycle confirm pulse. Pixel latency is 2 clk.
module menu_renderer
    import menu_pkg::*;
#(
    parameter int unsigned N_ITEMS      = 3,
    parameter int unsigned CHARS        = 6,
    parameter int unsigned X0           = 310,
    parameter int unsigned Y0           = 220,
    parameter int unsigned SCALE        = 2,
    parameter int unsigned PAD          = 8,
    parameter int unsigned GAP          = 4,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Hcount,
    input  logic [15:0] Vcount,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    input  logic        reopen,
    output logic [3:0]  r_red,
    output logic [3:0]  r_green,
    output logic [3:0]  r_blue,
    output logic [2:0]  sel_idx,
    output logic        sel_valid
);

    localparam int unsigned CELL    = GLYPH_W * SCALE;
    localparam int unsigned ROW_H   = CELL + GAP;
    localparam int unsigned BOX_W   = CHARS * CELL + 2 * PAD;
    localparam int unsigned BOX_H   = N_ITEMS * ROW_H - GAP + 2 * PAD;
    localparam int unsigned CELL_SH = $clog2(CELL);
    localparam int unsigned SC_SH   = $clog2(SCALE);
    localparam int unsigned FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [15:0] BX0 = 16'(X0);
    localparam logic [15:0] BX1 = 16'(X0 + BOX_W);
    localparam logic [15:0] BY0 = 16'(Y0);
    localparam logic [15:0] BY1 = 16'(Y0 + BOX_H);
    localparam logic [15:0] CX0 = 16'(X0 + PAD);
    localparam logic [15:0] CX1 = 16'(X0 + PAD + CHARS * CELL);
    localparam logic [15:0] CY0 = 16'(Y0 + PAD);

    localparam logic [2:0]    LAST_IDX   = 3'(N_ITEMS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Control state
    state_e        state_q, state_d;
    logic [2:0]    cursor_q, cursor_d;
    logic [2:0]    disp_q, disp_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic          sel_valid_q, sel_valid_d;
    logic          frame_start;

    // Pixel pipeline
    logic          in_box_q, in_box_d;
    logic          in_cell_q, in_cell_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    colour_q, colour_d;
    logic [15:0]   hx, vy, yoff, col;
    logic          row_hit;
    logic [5:0]    char_code;
    logic [2:0]    glyph_row;
    logic [7:0]    rom_bits;
    logic          glyph_px;
    logic          highlight;

    assign frame_start = (Hcount == 16'd0) && (Vcount == 16'd0);

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        sel_valid_d = 1'b0;
        disp_d      = disp_q;
        frame_d     = frame_q;
        blink_d     = blink_q;

        case (state_q)
            ST_NAV: begin
                if (btn_sel) begin
                    state_d     = ST_DONE;
                    sel_valid_d = 1'b1;
                end else if (btn_down && !btn_up) begin
                    cursor_d = (cursor_q == LAST_IDX) ? 3'd0 : cursor_q + 3'd1;
                end else if (btn_up && !btn_down) begin
                    cursor_d = (cursor_q == 3'd0) ? LAST_IDX : cursor_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (reopen) state_d = ST_NAV;
            end
            default: state_d = ST_NAV;
        endcase

        if (frame_start) begin
            disp_d = cursor_q;
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Stage 1: region decode; the ROM address is issued from the same decode so
    // its registered row lands alongside the stage-1 flags.
    always_comb begin
        hx        = Hcount - CX0;
        vy        = Vcount - CY0;
        in_box_d  = (Hcount >= BX0) && (Hcount < BX1) && (Vcount >= BY0) && (Vcount < BY1);
        row_hit   = 1'b0;
        row_d     = 3'd0;
        yoff      = 16'd0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if ((Vcount >= CY0) && (vy >= 16'(i * ROW_H)) && (vy < 16'(i * ROW_H + CELL))) begin
                row_hit = 1'b1;
                row_d   = 3'(i);
                yoff    = vy - 16'(i * ROW_H);
            end
        end
        in_cell_d = row_hit && (Hcount >= CX0) && (Hcount < CX1);
        col       = hx >> CELL_SH;
        bit_d     = 3'(hx[CELL_SH-1:0] >> SC_SH);
        glyph_row = 3'(yoff >> SC_SH);
        char_code = item_char(row_d, col);
    end

    menu_font_rom u_font_rom (
        .clk    (clk),
        .code_i (char_code),
        .row_i  (glyph_row),
        .bits_o (rom_bits)
    );

    // Stage 2: glyph bit select and colour mux
    always_comb begin
        glyph_px  = in_cell_q && rom_bits[3'd7 - bit_q];
        highlight = in_cell_q && (row_q == disp_q) && ((state_q == ST_DONE) || blink_q);
        colour_d  = 4'h0;
        if (in_box_q) colour_d = (glyph_px ^ highlight) ? 4'h0 : 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_NAV;
            cursor_q    <= 3'd0;
            disp_q      <= 3'd0;
            frame_q     <= '0;
            blink_q     <= 1'b1;
            sel_valid_q <= 1'b0;
            in_box_q    <= 1'b0;
            in_cell_q   <= 1'b0;
            row_q       <= 3'd0;
            bit_q       <= 3'd0;
            colour_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            disp_q      <= disp_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
            sel_valid_q <= sel_valid_d;
            in_box_q    <= in_box_d;
            in_cell_q   <= in_cell_d;
            row_q       <= row_d;
            bit_q       <= bit_d;
            colour_q    <= colour_d;
        end
    end

    assign r_red     = colour_q;
    assign r_green   = colour_q;
    assign r_blue    = colour_q;
    assign sel_idx   = cursor_q;
    assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_menu_renderer.sv
// Directed self-checking bench for menu_renderer at default parameters.
module tb_menu_renderer;

    localparam logic [15:0] IDLE = 16'd600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Hcount = IDLE;
    logic [15:0] Vcount = IDLE;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_sel = 1'b0;
    logic        reopen = 1'b0;
    logic [3:0]  r_red, r_green, r_blue;
    logic [2:0]  sel_idx;
    logic        sel_valid;

    int total = 0;
    int bad   = 0;

    menu_renderer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Hcount    (Hcount),
        .Vcount    (Vcount),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_sel   (btn_sel),
        .reopen    (reopen),
        .r_red     (r_red),
        .r_green   (r_green),
        .r_blue    (r_blue),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Present one pixel for exactly one cycle, then sample its colour 2 cycles later.
    task automatic pixel(input logic [15:0] h, input logic [15:0] v, output logic [11:0] c);
        @(negedge clk); Hcount = h; Vcount = v;
        @(negedge clk); Hcount = IDLE; Vcount = IDLE;
        @(posedge clk); #1 c = {r_red, r_green, r_blue};
    endtask

    task automatic press(input logic u, input logic d, input logic s, input logic ro);
        @(negedge clk); btn_up = u; btn_down = d; btn_sel = s; reopen = ro;
        @(negedge clk); btn_up = 0; btn_down = 0; btn_sel = 0; reopen = 0;
    endtask

    task automatic frame_tick;
        @(negedge clk); Hcount = 16'd0; Vcount = 16'd0;
        @(negedge clk); Hcount = IDLE; Vcount = IDLE;
    endtask

    task automatic do_reset;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [11:0] c;
        do_reset;
        press(0, 1, 0, 0);
        total++;
        if (sel_idx !== 3'd1) begin bad++; $display("FAIL pre_reset_idx: got %0d want 1", sel_idx); end
        @(negedge clk); Hcount = 16'd312; Vcount = 16'd222;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if ({r_red, r_green, r_blue} !== 12'hFFF) begin bad++; $display("FAIL pre_reset_colour: got %h want fff", {r_red, r_green, r_blue}); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({r_red, r_green, r_blue} !== 12'h000) begin bad++; $display("FAIL reset_colour: got %h want 000", {r_red, r_green, r_blue}); end
        total++;
        if (sel_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", sel_idx); end
        total++;
        if (sel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sel_valid); end
        Hcount = IDLE; Vcount = IDLE;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        pixel(16'd300, 16'd200, c);
        total++;
        if (c !== 12'h000) begin bad++; $display("FAIL outside_px: got %h want 000", c); end
        pixel(16'd312, 16'd222, c);
        total++;
        if (c !== 12'hFFF) begin bad++; $display("FAIL padding_px: got %h want fff", c); end
    endtask

    task automatic test_nav_wrap;
        logic [2:0] exp_dn [4] = '{3'd1, 3'd2, 3'd0, 3'd1};
        logic [2:0] exp_up [2] = '{3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            press(0, 1, 0, 0);
            total++;
            if (sel_idx !== exp_dn[i]) begin bad++; $display("FAIL nav_down%0d: got %0d want %0d", i, sel_idx, exp_dn[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            press(1, 0, 0, 0);
            total++;
            if (sel_idx !== exp_up[i]) begin bad++; $display("FAIL nav_up%0d: got %0d want %0d", i, sel_idx, exp_up[i]); end
        end
        press(1, 1, 0, 0);
        total++;
        if (sel_idx !== 3'd2) begin bad++; $display("FAIL nav_both: got %0d want 2", sel_idx); end
        total++;
        if (sel_valid !== 1'b0) begin bad++; $display("FAIL nav_no_valid: got %b want 0", sel_valid); end
    endtask

    task automatic test_confirm;
        press(1, 0, 1, 0);
        total++;
        if (sel_valid !== 1'b1) begin bad++; $display("FAIL confirm_pulse: got %b want 1", sel_valid); end
        total++;
        if (sel_idx !== 3'd2) begin bad++; $display("FAIL confirm_idx: got %0d want 2", sel_idx); end
        @(negedge clk);
        total++;
        if (sel_valid !== 1'b0) begin bad++; $display("FAIL confirm_width: got %b want 0", sel_valid); end
        press(0, 1, 0, 0);
        total++;
        if (sel_idx !== 3'd2) begin bad++; $display("FAIL done_ignore_down: got %0d want 2", sel_idx); end
        press(0, 0, 1, 0);
        total++;
        if (sel_valid !== 1'b0) begin bad++; $display("FAIL done_ignore_sel: got %b want 0", sel_valid); end
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        total++;
        if (sel_idx !== 3'd0) begin bad++; $display("FAIL reopen_down: got %0d want 0", sel_idx); end
    endtask

    task automatic test_blink;
        logic [11:0] c;
        logic [11:0] want;
        do_reset;
        for (int k = 0; k <= 60; k++) begin
            want = (k < 30 || k >= 60) ? 12'h000 : 12'hFFF;
            pixel(16'd318, 16'd228, c);
            total++;
            if (c !== want) begin bad++; $display("FAIL blink_f%0d: got %h want %h", k, c, want); end
            frame_tick;
        end
        press(0, 0, 1, 0);
        for (int k = 0; k < 35; k++) begin
            pixel(16'd318, 16'd228, c);
            total++;
            if (c !== 12'h000) begin bad++; $display("FAIL done_hl_f%0d: got %h want 000", k, c); end
            frame_tick;
        end
    endtask

    task automatic test_tearing;
        logic [11:0] c;
        do_reset;
        Hcount = 16'd100; Vcount = 16'd240;
        press(0, 1, 0, 0);
        total++;
        if (sel_idx !== 3'd1) begin bad++; $display("FAIL tear_idx: got %0d want 1", sel_idx); end
        pixel(16'd318, 16'd228, c);
        total++;
        if (c !== 12'h000) begin bad++; $display("FAIL tear_row0_held: got %h want 000", c); end
        pixel(16'd318, 16'd248, c);
        total++;
        if (c !== 12'hFFF) begin bad++; $display("FAIL tear_row1_early: got %h want fff", c); end
        frame_tick;
        pixel(16'd318, 16'd248, c);
        total++;
        if (c !== 12'h000) begin bad++; $display("FAIL tear_row1_moved: got %h want 000", c); end
        pixel(16'd318, 16'd228, c);
        total++;
        if (c !== 12'hFFF) begin bad++; $display("FAIL tear_row0_cleared: got %h want fff", c); end
    endtask

    task automatic test_glyph;
        logic [11:0] c;
        logic [11:0] want;
        logic [63:0] s_glyph;
        logic [15:0] ex [6] = '{16'd322, 16'd318, 16'd318, 16'd400, 16'd421, 16'd422};
        logic [15:0] ey [6] = '{16'd248, 16'd248, 16'd244, 16'd270, 16'd230, 16'd230};
        logic [11:0] ew [6] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
        s_glyph = 64'h3C66603C06663C00;
        do_reset;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                want = s_glyph[8 * (7 - y / 2) + (7 - x / 2)] ? 12'hFFF : 12'h000;
                pixel(16'(318 + x), 16'(228 + y), c);
                total++;
                if (c !== want) begin bad++; $display("FAIL glyph_S(%0d,%0d): got %h want %h", 318 + x, 228 + y, c, want); end
            end
        end
        for (int i = 0; i < 6; i++) begin
            pixel(ex[i], ey[i], c);
            total++;
            if (c !== ew[i]) begin bad++; $display("FAIL edge(%0d,%0d): got %h want %h", ex[i], ey[i], c, ew[i]); end
        end
        pixel(16'd320, 16'd291, c);
        total++;
        if (c !== 12'hFFF) begin bad++; $display("FAIL box_bottom_in: got %h want fff", c); end
        pixel(16'd320, 16'd292, c);
        total++;
        if (c !== 12'h000) begin bad++; $display("FAIL box_bottom_out: got %h want 000", c); end
    endtask

    initial begin
        test_reset;
        test_nav_wrap;
        test_confirm;
        test_blink;
        test_tearing;
        test_glyph;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
